// File: rtl/fp64_pkg.sv
// Shared binary64 field widths, constants, class/state enums and operand unpacking.
// With FP_MUL_SUBNORM_EN defined, subnormal operands are pre-normalised here.
package fp64_pkg;

  localparam int EXP_W = 11;
  localparam int MAN_W = 52;
  localparam int BIAS  = 1023;

  localparam logic [63:0] QNAN    = 64'h7FF8_0000_0000_0000;
  localparam logic [63:0] POS_INF = 64'h7FF0_0000_0000_0000;

  typedef enum logic [2:0] {ZERO, SUB, NORM, INF, NAN} cls_e;
  typedef enum logic [2:0] {S_IDLE, S_UNPACK, S_MUL, S_NORM, S_ROUND} state_e;

  typedef struct packed {
    logic               sign;
    logic signed [12:0] exp;
    logic [MAN_W:0]     mant;
    cls_e               cls;
  } unpacked_t;

`ifdef FP_MUL_SUBNORM_EN
  function automatic logic [5:0] lzc53(input logic [52:0] m);
    logic [5:0] n;
    n = 6'd53;
    for (int unsigned i = 0; i < 53; i++) begin
      if (m[i]) n = 6'(52 - i);
    end
    return n;
  endfunction
`endif

  function automatic unpacked_t unpack(input logic [63:0] x);
    unpacked_t        u;
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
`ifdef FP_MUL_SUBNORM_EN
    logic [5:0]       lz;
`endif
    e      = x[62:52];
    f      = x[51:0];
    u.sign = x[63];
    u.exp  = $signed({2'b00, e});
    u.mant = {1'b1, f};
    u.cls  = NORM;
    if (e == '1) begin
      u.cls = (f == '0) ? INF : NAN;
    end else if (e == '0) begin
      u.mant = {1'b0, f};
      u.exp  = 13'sd1;
      if (f == '0) begin
        u.cls = ZERO;
      end else begin
`ifdef FP_MUL_SUBNORM_EN
        // Shift the leading one up to the hidden-bit position; exponent goes below 1.
        u.cls  = SUB;
        lz     = lzc53({1'b0, f});
        u.mant = {1'b0, f} << lz;
        u.exp  = 13'sd1 - $signed({7'b0, lz});
`else
        u.cls  = ZERO;
`endif
      end
    end
    return u;
  endfunction

endpackage

// File: rtl/fp64_mul_responder_if.sv
// valid/finish request bus between a CMU FSM (master) and the multiplier (slave).
interface fp64_mul_responder_if #(parameter int DBL_WIDTH = 64);
  logic                 valid;
  logic [DBL_WIDTH-1:0] a;
  logic [DBL_WIDTH-1:0] b;
  logic                 finish;
  logic [DBL_WIDTH-1:0] result;
  logic                 busy;

  modport master (output valid, a, b, input finish, result, busy);
  modport slave  (input valid, a, b, output finish, result, busy);
endinterface

// File: rtl/fp64_round_pack.sv
// Combinational round-to-nearest-even and packing of the normalised product.
// FP_MUL_SUBNORM_EN selects gradual underflow; otherwise tiny results flush to zero.
module fp64_round_pack
  import fp64_pkg::*;
(
  input  logic               sign,
  input  logic signed [12:0] exp_in,
  input  logic [105:0]       mant,
  input  cls_e               cls_a,
  input  cls_e               cls_b,
  output logic [63:0]        word
);

  logic [105:0]       shifted;
  logic [52:0]        m53;
  logic               g, r, s, round_up;
  logic [53:0]        sum;
  logic signed [12:0] exp_f;
  logic [51:0]        frac;
  logic [63:0]        arith;
`ifdef FP_MUL_SUBNORM_EN
  logic               tiny;
  logic signed [12:0] sh_full;
  logic [6:0]         sh;
`endif

  always_comb begin
`ifdef FP_MUL_SUBNORM_EN
    tiny    = (exp_in <= 13'sd0);
    sh_full = 13'sd1 - exp_in;
    sh      = '0;
    if (tiny) sh = (sh_full > 13'sd106) ? 7'd106 : sh_full[6:0];
    // Bits shifted out of the bottom are kept alive as sticky in bit 0.
    shifted    = mant >> sh;
    shifted[0] = shifted[0] | (|(mant & ~({106{1'b1}} << sh)));
`else
    shifted = mant;
`endif
    m53      = shifted[104:52];
    g        = shifted[51];
    r        = shifted[50];
    s        = |shifted[49:0];
    round_up = g & (r | s | m53[0]);
    sum      = {1'b0, m53} + {53'b0, round_up};
    exp_f    = exp_in;
    frac     = sum[51:0];
    if (sum[53]) begin
      frac  = sum[52:1];
      exp_f = exp_in + 13'sd1;
    end

`ifdef FP_MUL_SUBNORM_EN
    // A carry into bit 52 promotes the subnormal to the minimum normal encoding.
    if (tiny)                      arith = {sign, 10'b0, sum[52], sum[51:0]};
    else if (exp_f >= 13'sd2047)   arith = POS_INF | {sign, 63'b0};
    else                           arith = {sign, exp_f[10:0], frac};
`else
    if (exp_f >= 13'sd2047)        arith = POS_INF | {sign, 63'b0};
    else if (exp_f <= 13'sd0)      arith = {sign, 63'b0};
    else                           arith = {sign, exp_f[10:0], frac};
`endif

    if (cls_a == NAN || cls_b == NAN)                                 word = QNAN;
    else if ((cls_a == INF && cls_b == ZERO) ||
             (cls_a == ZERO && cls_b == INF))                         word = QNAN;
    else if (cls_a == INF || cls_b == INF)                            word = POS_INF | {sign, 63'b0};
    else if (cls_a == ZERO || cls_b == ZERO)                          word = {sign, 63'b0};
    else                                                              word = arith;
  end

endmodule

// File: rtl/fp64_mul_responder.sv
// Multi-cycle binary64 multiplier on the valid/finish bus: 53x4 shift-add over
// 14 cycles, fixed 17-cycle latency. Optional FP_MUL_SUBNORM_EN enables subnormals.
module fp64_mul_responder
  import fp64_pkg::*;
#(
  parameter int DBL_WIDTH = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  fp64_mul_responder_if.slave  bus
);

  if (DBL_WIDTH != 64) begin : g_width_check
    $error("fp64_mul_responder: DBL_WIDTH must be 64");
  end

  state_e             state_q, state_d;
  logic [63:0]        a_q, a_d, b_q, b_d;
  logic               sign_q, sign_d;
  logic signed [12:0] exp_q, exp_d;
  logic [52:0]        mant_a_q, mant_a_d, mant_b_q, mant_b_d;
  cls_e               cls_a_q, cls_a_d, cls_b_q, cls_b_d;
  logic [105:0]       acc_q, acc_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [63:0]        result_q, result_d;
  logic               finish_q, finish_d;
  logic               busy_q, busy_d;

  unpacked_t          ua, ub;
  logic [55:0]        mant_b_pad;
  logic [3:0]         nib;
  logic [105:0]       pp;
  logic [63:0]        packed_word;

  fp64_round_pack u_round_pack (
    .sign   (sign_q),
    .exp_in (exp_q),
    .mant   (acc_q),
    .cls_a  (cls_a_q),
    .cls_b  (cls_b_q),
    .word   (packed_word)
  );

  always_comb begin
    ua         = unpack(a_q);
    ub         = unpack(b_q);
    mant_b_pad = {3'b0, mant_b_q};
    nib        = mant_b_pad[{cnt_q, 2'b00} +: 4];
    pp         = ({53'b0, mant_a_q} * {102'b0, nib}) << {cnt_q, 2'b00};

    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_d   = sign_q;
    exp_d    = exp_q;
    mant_a_d = mant_a_q;
    mant_b_d = mant_b_q;
    cls_a_d  = cls_a_q;
    cls_b_d  = cls_b_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    finish_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          state_d = S_UNPACK;
        end
      end
      S_UNPACK: begin
        sign_d   = ua.sign ^ ub.sign;
        exp_d    = ua.exp + ub.exp - 13'(BIAS);
        mant_a_d = ua.mant;
        mant_b_d = ub.mant;
        cls_a_d  = ua.cls;
        cls_b_d  = ub.cls;
        acc_d    = '0;
        cnt_d    = '0;
        state_d  = S_MUL;
      end
      S_MUL: begin
        acc_d = acc_q + pp;
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == 4'd13) state_d = S_NORM;
      end
      S_NORM: begin
        // Product in [2,4): halve it, folding the dropped bit into sticky.
        if (acc_q[105]) begin
          acc_d = {1'b0, acc_q[105:1]} | {105'b0, acc_q[0]};
          exp_d = exp_q + 13'sd1;
        end
        state_d = S_ROUND;
      end
      S_ROUND: begin
        result_d = packed_word;
        finish_d = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      sign_q   <= 1'b0;
      exp_q    <= '0;
      mant_a_q <= '0;
      mant_b_q <= '0;
      cls_a_q  <= ZERO;
      cls_b_q  <= ZERO;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      finish_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_q   <= sign_d;
      exp_q    <= exp_d;
      mant_a_q <= mant_a_d;
      mant_b_q <= mant_b_d;
      cls_a_q  <= cls_a_d;
      cls_b_q  <= cls_b_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      finish_q <= finish_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.finish = finish_q;
  assign bus.result = result_q;
  assign bus.busy   = busy_q;

endmodule

// File: doc/fp64_mul_responder.md
# fp64_mul_responder

Multi-cycle IEEE-754 binary64 multiplier that serves the valid/finish request protocol used by the covariance-update CMU datapaths. A CMU FSM drives a one-cycle `valid` pulse with operands. This block answers with a one-cycle `finish` pulse and a held `result` after a fixed latency. It is area-lean: one 53x4 partial-product slice is reused over 14 iterations, so several CMUs can instantiate it cheaply.

## Interface
- `DBL_WIDTH`, default 64: operand width; only 64 is legal, elaboration error otherwise.

- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `valid`  in  1  request pulse; `a`/`b` sampled on the same edge
- `a`  in  DBL_WIDTH  multiplicand, binary64
- `b`  in  DBL_WIDTH  multiplier, binary64
- `finish`  out  1  one-cycle completion pulse
- `result`  out  DBL_WIDTH  product; stable from `finish` until the next `finish`
- `busy`  out  1  high whenever state != S_IDLE

## Operation
- **Reset values:** state S_IDLE, `finish`=0, `result`=0, `busy`=0, all internal registers 0.
- **States:**
  - S_IDLE: on `valid`, capture `a`, `b`, go to S_UNPACK.
  - S_UNPACK: split sign, exponent and mantissa; insert hidden bit; classify the operands (zero/sub/normal/inf/NaN); clear the accumulator and set cnt=0; go to S_MUL.
  - S_MUL: do a radix-16 shift-add. acc += mant_a * mant_b[4*cnt+3:4*cnt] << 4*cnt. mant_b is zero-padded to 56 bits. The 106-bit accumulator is sufficient. cnt is 4 bits. Leave when cnt==13, i.e. after 14 iterations; go to S_NORM.
  - S_NORM: if acc[105] is set, shift right by 1 and increment the exponent. Exponent = ea+eb-1023, kept in 13-bit signed arithmetic. Go to S_ROUND.
  - S_ROUND: round to nearest, ties to even, using guard/round/sticky. A mantissa carry-out increments the exponent. Apply specials, register `result`, pulse `finish`=1, return to S_IDLE.
- **Sign:** sa XOR sb for every result, including zero and inf. NaN results ignore this rule.
- **Specials:** these override the arithmetic path. They are still delivered with the full fixed latency.
  - Any NaN input gives the canonical qNaN 0x7FF8_0000_0000_0000.
  - inf × 0 gives qNaN.
  - inf × finite non-zero gives signed inf.
  - 0 × finite gives signed zero.
- **Overflow:** a final exponent ≥ 2047 gives signed inf 0x7FF0_0000_0000_0000 with the sign OR'ed in.
- **Underflow:** behaviour depends on the configuration (see Configuration).
- **`valid` while busy:** the request is ignored. No queueing and no error. The in-flight operation is unaffected.
- **Reset mid-operation:** the operation is aborted and no `finish` is issued. `result` returns to 0.

## Timing
- `valid` sampled at edge E0. `finish` rises at edge E17 and falls at E18. Fixed latency is 17 cycles for every operand class.
- `result` is updated at E17 only.
- The block is back in S_IDLE after E17. A `valid` at E18 is accepted, giving a throughput of 1 op per 18 cycles.
- A `valid` sampled at E17 (state S_ROUND) is ignored.
- `busy` is high from E0+ through E17−; it is low after E17.

## Configuration
- **`FP_MUL_SUBNORM_EN` defined:**
  - Subnormal inputs are pre-normalised in S_UNPACK using a leading-zero count. The fixed latency is kept, because the leading-zero count is done within the same cycle.
  - Tiny results are denormalised with a right shift before rounding. A result that rounds up to the minimum normal is encoded as normal.
- **Not defined:**
  - Subnormal inputs are treated as signed zero.
  - Any result with a biased exponent ≤ 0 after rounding is flushed to signed zero.

## Structure
- **Package `fp64_pkg`:**
  - field widths: EXP_W=11, MAN_W=52
  - BIAS=1023
  - constants QNAN, POS_INF
  - class enum: ZERO, SUB, NORM, INF, NAN
  - state enum: S_IDLE, S_UNPACK, S_MUL, S_NORM, S_ROUND
- **Sub-module `fp64_round_pack`:** combinational. Takes sign, exponent, the 106-bit normalised mantissa and the operand classes; produces the packed 64-bit word. The top module owns the FSM and the accumulator.

## Test plan
- a=0x4000000000000000 (2.0), b=0x4008000000000000 (3.0), `valid` at E0 → `finish` high exactly at E17 with `result`=0x4018000000000000; `busy` low at E18.
- Tie-to-even: a=0x3FF0000000000001, b=0x3FF8000000000000 → 0x3FF8000000000002.
- Specials, each with 17-cycle latency:
  - inf × zero (0x7FF0000000000000 × 0x8000000000000000) → 0x7FF8000000000000.
  - 0xFFF0000000000000 × 0x4000000000000000 → 0xFFF0000000000000.
  - NaN input → 0x7FF8000000000000.
- Overflow: 0x7FE0000000000000 × 0x4000000000000000 → 0x7FF0000000000000.
- Underflow: 0x0010000000000000 × 0x3FE0000000000000 → 0x0008000000000000 with `FP_MUL_SUBNORM_EN`, 0x0000000000000000 without.
- Robustness:
  - A second `valid` with different operands at E5 is ignored; the E17 result matches the first pair only.
  - `rst_n` low at E8 → no `finish` and `result`=0; a new `valid` after reset release completes normally in 17 cycles.
